// File: rtl/pc_stack_gen.sv
// Program-counter stack for the 4004-style core: word-serial increment, push/pop/jump, word loads.
// Build option PC_STACK_GUARD_EN adds an occupancy counter with sticky overflow/underflow flags.
module pc_stack_gen #(
    parameter int unsigned WORD_W = 4,
    parameter int unsigned NWORDS = 3,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PC_W  = WORD_W * NWORDS,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        cycle,
    input  logic [1:0]        control,
    input  logic [PC_W-1:0]   target,
    input  logic [1:0]        pc_next_sel,
    input  logic [WORD_W-1:0] data,
    input  logic [WORD_W-1:0] regval,
    input  logic [WORD_W-1:0] inst_operand,
    input  logic [NWORDS-1:0] pc_write_enable,
    output logic [PC_W-1:0]   pc,
    output logic              pc_enable,
    output logic [WORD_W-1:0] pc_word,
    output logic [PTR_W-1:0]  sp,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [1:0] CtlHold = 2'b00;
    localparam logic [1:0] CtlPush = 2'b01;
    localparam logic [1:0] CtlPop  = 2'b10;
    localparam logic [1:0] CtlJump = 2'b11;

    logic [PC_W-1:0]   slots_q [DEPTH];
    logic [PC_W-1:0]   slots_d [DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic              carry_q, carry_d;

    logic [PC_W-1:0]   active;
    logic              fetch;
    logic              do_push;
    logic              do_pop;
    logic [WORD_W-1:0] src_word;
    logic [WORD_W:0]   sum;
    logic              found;
    int unsigned       cyc;

    assign cyc    = 32'(cycle);
    assign fetch  = (cyc < NWORDS);
    assign active = slots_q[sp_q];

    always_comb begin
        unique case (pc_next_sel)
            2'd0:    src_word = data;
            2'd1:    src_word = regval;
            2'd2:    src_word = inst_operand;
            default: src_word = '0;
        endcase
    end

    always_comb begin
        slots_d = slots_q;
        sp_d    = sp_q;
        carry_d = carry_q;
        sum     = '0;
        found   = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (fetch) begin
            // Word 0 always adds one; higher words add the carry rippled from the previous cycle.
            for (int unsigned w = 0; w < NWORDS; w++) begin
                if (cyc == w) begin
                    sum = {1'b0, active[w*WORD_W +: WORD_W]}
                        + {{WORD_W{1'b0}}, ((w == 0) ? 1'b1 : carry_q)};
                    slots_d[sp_q][w*WORD_W +: WORD_W] = sum[WORD_W-1:0];
                    carry_d = sum[WORD_W];
                end
            end
        end else if (|pc_write_enable) begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
                if (pc_write_enable[w] && !found) begin
                    found = 1'b1;
                    slots_d[sp_q][w*WORD_W +: WORD_W] = src_word;
                end
            end
        end else begin
            unique case (control)
                CtlPush: begin
                    do_push = 1'b1;
                    sp_d = sp_q + PTR_W'(1);
                    slots_d[sp_q + PTR_W'(1)] = target;
                end
                CtlPop: begin
                    do_pop = 1'b1;
                    sp_d = sp_q - PTR_W'(1);
                end
                CtlJump: slots_d[sp_q] = target;
                CtlHold: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) slots_q[i] <= '0;
            sp_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            slots_q <= slots_d;
            sp_q    <= sp_d;
            carry_q <= carry_d;
        end
    end

`ifdef PC_STACK_GUARD_EN
    logic [PTR_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Occupancy counts saved return addresses; sp itself still wraps freely.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (do_push) begin
            if (occ_q == PTR_W'(DEPTH - 1)) ovf_d = 1'b1;
            else                            occ_d = occ_q + PTR_W'(1);
        end else if (do_pop) begin
            if (occ_q == '0) unf_d = 1'b1;
            else             occ_d = occ_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always_comb begin
        pc        = active;
        sp        = sp_q;
        pc_enable = fetch;
        pc_word   = '0;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (cyc == w) pc_word = active[w*WORD_W +: WORD_W];
        end
    end

endmodule

// File: tb/tb_pc_stack_gen.sv
// Directed self-checking bench for pc_stack_gen (default parameters).
// Honours PC_STACK_GUARD_EN for the expected flag values.
module tb_pc_stack_gen;

`ifdef PC_STACK_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cycle;
    logic [1:0]  control;
    logic [11:0] target;
    logic [1:0]  pc_next_sel;
    logic [3:0]  data, regval, inst_operand;
    logic [2:0]  pc_write_enable;
    logic [11:0] pc;
    logic        pc_enable;
    logic [3:0]  pc_word;
    logic [1:0]  sp;
    logic        overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    pc_stack_gen dut (
        .clock(clock), .reset(reset), .cycle(cycle), .control(control), .target(target),
        .pc_next_sel(pc_next_sel), .data(data), .regval(regval), .inst_operand(inst_operand),
        .pc_write_enable(pc_write_enable), .pc(pc), .pc_enable(pc_enable), .pc_word(pc_word),
        .sp(sp), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; cycle = 3'd3; control = 2'b00; target = '0; pc_next_sel = 2'd0;
        data = '0; regval = '0; inst_operand = '0; pc_write_enable = '0;
    endtask

    task automatic ctl(input logic [1:0] c, input logic [11:0] t);
        idle(); control = c; target = t; tick(); idle();
    endtask

    task automatic apply_reset();
        idle(); reset = 1'b1; tick(); idle();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL reset_pc got %h want 000", pc); end
        n_cmp++; if (sp !== 2'd0) begin n_err++; $display("FAIL reset_sp got %0d want 0", sp); end
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got %b%b want 00", overflow, underflow); end
        n_cmp++; if (pc_enable !== 1'b0 || pc_word !== 4'h0) begin
            n_err++; $display("FAIL idle_out got en=%b w=%h want en=0 w=0", pc_enable, pc_word); end
    endtask

    // Fetches a full PC starting from value st and checks each streamed word.
    task automatic test_fetch(input string name, input logic [11:0] st, input logic [11:0] nxt);
        logic [11:0] v;
        v = st;
        for (int k = 0; k < 3; k++) begin
            cycle = 3'(k);
            #1;
            n_cmp++; if (pc_word !== v[k*4 +: 4] || pc_enable !== 1'b1) begin
                n_err++; $display("FAIL %s_word%0d got %h en=%b want %h en=1",
                                  name, k, pc_word, pc_enable, v[k*4 +: 4]); end
            tick();
        end
        idle();
        #1;
        n_cmp++; if (pc !== nxt) begin n_err++; $display("FAIL %s_pc got %h want %h", name, pc, nxt); end
    endtask

    task automatic test_push_pop();
        ctl(2'b11, 12'h123);
        ctl(2'b01, 12'h456);
        n_cmp++; if (sp !== 2'd1) begin n_err++; $display("FAIL push_sp got %0d want 1", sp); end
        n_cmp++; if (pc !== 12'h456) begin n_err++; $display("FAIL push_pc got %h want 456", pc); end
        ctl(2'b10, 12'h000);
        n_cmp++; if (sp !== 2'd0) begin n_err++; $display("FAIL pop_sp got %0d want 0", sp); end
        n_cmp++; if (pc !== 12'h123) begin n_err++; $display("FAIL pop_pc got %h want 123", pc); end
    endtask

    task automatic test_word_write();
        // Lowest enable bit wins; simultaneous jump is ignored.
        idle(); pc_write_enable = 3'b011; pc_next_sel = 2'd2; inst_operand = 4'hA;
        control = 2'b11; target = 12'h777; tick(); idle();
        n_cmp++; if (pc !== 12'h12A) begin n_err++; $display("FAIL wr_inst got %h want 12A", pc); end
        idle(); pc_write_enable = 3'b100; pc_next_sel = 2'd0; data = 4'h5; tick(); idle();
        n_cmp++; if (pc !== 12'h52A) begin n_err++; $display("FAIL wr_data got %h want 52A", pc); end
        idle(); pc_write_enable = 3'b010; pc_next_sel = 2'd1; regval = 4'h9; tick(); idle();
        n_cmp++; if (pc !== 12'h59A) begin n_err++; $display("FAIL wr_reg got %h want 59A", pc); end
        idle(); pc_write_enable = 3'b110; pc_next_sel = 2'd3; tick(); idle();
        n_cmp++; if (pc !== 12'h50A) begin n_err++; $display("FAIL wr_zero got %h want 50A", pc); end
        // Fetch in the same clock overrides the write.
        idle(); cycle = 3'd0; pc_write_enable = 3'b011; pc_next_sel = 2'd2; inst_operand = 4'h3;
        tick(); idle();
        n_cmp++; if (pc !== 12'h50B) begin n_err++; $display("FAIL wr_vs_fetch got %h want 50B", pc); end
    endtask

    task automatic test_reset_mid_fetch();
        ctl(2'b11, 12'h00F);
        idle(); cycle = 3'd0; reset = 1'b1; tick(); idle();
        n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL midrst_pc got %h want 000", pc); end
        // A surviving carry would bump word 1 here.
        idle(); cycle = 3'd1; tick(); idle();
        n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL midrst_carry got %h want 000", pc); end
    endtask

    task automatic test_guard();
        apply_reset();
        ctl(2'b01, 12'h111);
        ctl(2'b01, 12'h222);
        ctl(2'b01, 12'h333);
        n_cmp++; if (sp !== 2'd3 || overflow !== 1'b0) begin
            n_err++; $display("FAIL push3 got sp=%0d ovf=%b want sp=3 ovf=0", sp, overflow); end
        ctl(2'b01, 12'h444);
        n_cmp++; if (sp !== 2'd0 || pc !== 12'h444) begin
            n_err++; $display("FAIL push4 got sp=%0d pc=%h want sp=0 pc=444", sp, pc); end
        n_cmp++; if (overflow !== Guard) begin
            n_err++; $display("FAIL overflow got %b want %b", overflow, Guard); end
        ctl(2'b00, 12'hFFF);
        n_cmp++; if (overflow !== Guard || pc !== 12'h444) begin
            n_err++; $display("FAIL ovf_sticky got ovf=%b pc=%h want ovf=%b pc=444", overflow, pc, Guard); end
        apply_reset();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
        ctl(2'b10, 12'h000);
        n_cmp++; if (sp !== 2'd3 || pc !== 12'h000) begin
            n_err++; $display("FAIL pop_empty got sp=%0d pc=%h want sp=3 pc=000", sp, pc); end
        n_cmp++; if (underflow !== Guard || overflow !== 1'b0) begin
            n_err++; $display("FAIL underflow got unf=%b ovf=%b want unf=%b ovf=0",
                              underflow, overflow, Guard); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch("zero", 12'h000, 12'h001);
        ctl(2'b11, 12'h0FF);
        test_fetch("ripple", 12'h0FF, 12'h100);
        ctl(2'b11, 12'hFFF);
        test_fetch("wrap", 12'hFFF, 12'h000);
        test_push_pop();
        test_word_write();
        test_reset_mid_fetch();
        test_guard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
